// File: rtl/crc_stream_if.sv
// Beat/result handshake bundle for the streaming CRC engine.
// master = beat source and result consumer, slave = engine.
interface crc_stream_if #(
    parameter int DATA_BYTES = 8,
    parameter int CRC_WIDTH  = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_BYTES*8-1:0] in_data;
    logic [DATA_BYTES-1:0]   in_keep;
    logic                    in_first;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [CRC_WIDTH-1:0]    out_crc;
    logic                    busy;

    modport master (
        output in_valid, in_data, in_keep, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_crc, busy
    );

    modport slave (
        input  in_valid, in_data, in_keep, in_first, in_last, out_ready,
        output in_ready, out_valid, out_crc, busy
    );
endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: per-frame latched config, keep-masked beats,
// BYTES_PER_CYCLE bytes folded per clock, MSB byte of each beat first.
module crc_stream_engine #(
    parameter int DATA_BYTES      = 8,
    parameter int CRC_WIDTH       = 32,
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [CRC_WIDTH-1:0] cfg_poly,
    input  logic [CRC_WIDTH-1:0] cfg_init,
    input  logic [CRC_WIDTH-1:0] cfg_xorout,
    input  logic                 cfg_refin,
    input  logic                 cfg_refout,
    crc_stream_if.slave          s
);
    localparam int STEPS = DATA_BYTES / BYTES_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);
    localparam logic [CW-1:0] FIN_STEP  = CW'(STEPS);

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_BYTES*8-1:0] data_q;
    logic [DATA_BYTES-1:0]   keep_q;
    logic                    last_q;
    logic [CW-1:0]           cnt_q;
    logic [CRC_WIDTH-1:0]    crc_q, crc_nxt, crc_fin;
    logic [CRC_WIDTH-1:0]    poly_q, xorout_q, out_crc_q;
    logic                    refin_q, refout_q;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] revw(input logic [CRC_WIDTH-1:0] v);
        logic [CRC_WIDTH-1:0] r;
        for (int i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] crc_byte(
        input logic [CRC_WIDTH-1:0] c,
        input logic [7:0]           b,
        input logic                 rin,
        input logic [CRC_WIDTH-1:0] poly
    );
        logic [CRC_WIDTH-1:0] r;
        r = c;
        r[CRC_WIDTH-1 -: 8] = r[CRC_WIDTH-1 -: 8] ^ (rin ? rev8(b) : b);
        for (int i = 0; i < 8; i++)
            r = r[CRC_WIDTH-1] ? ((r << 1) ^ poly) : (r << 1);
        return r;
    endfunction

    // The beat is shifted left as it is consumed, so the bytes due this
    // cycle always sit at the top of data_q/keep_q.
    always_comb begin
        crc_nxt = crc_q;
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            if (keep_q[DATA_BYTES-1-k])
                crc_nxt = crc_byte(crc_nxt, data_q[(DATA_BYTES-1-k)*8 +: 8],
                                   refin_q, poly_q);
        end
    end

    assign crc_fin = (refout_q ? revw(crc_q) : crc_q) ^ xorout_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (s.in_valid) state_d = PROC;
            PROC: begin
                if (cnt_q == LAST_STEP && !last_q) state_d = IDLE;
                else if (cnt_q == FIN_STEP)        state_d = DONE;
            end
            DONE: if (s.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s.in_ready  = (state_q == IDLE);
        s.out_valid = (state_q == DONE);
        s.busy      = (state_q != IDLE);
        s.out_crc   = out_crc_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            crc_q     <= '0;
            poly_q    <= '0;
            xorout_q  <= '0;
            refin_q   <= 1'b0;
            refout_q  <= 1'b0;
            out_crc_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s.in_valid) begin
                        data_q <= s.in_data;
                        keep_q <= s.in_keep;
                        last_q <= s.in_last;
                        cnt_q  <= '0;
                        if (s.in_first) begin
                            poly_q   <= cfg_poly;
                            xorout_q <= cfg_xorout;
                            refin_q  <= cfg_refin;
                            refout_q <= cfg_refout;
                            crc_q    <= cfg_init;
                        end
                    end
                end
                PROC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == FIN_STEP) begin
                        out_crc_q <= crc_fin;
                    end else begin
                        crc_q  <= crc_nxt;
                        data_q <= data_q << (8 * BYTES_PER_CYCLE);
                        keep_q <= keep_q << BYTES_PER_CYCLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
